// File: rtl/alu_iter_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_iter_sequencer
// Purpose  : Multi-cycle unsigned MUL (low word), DIVU and REMU built by
//            iterating an external combinational ADD/SUB ALU, one step per
//            clock, 32 steps per operation. Divide by zero short-circuits
//            straight to FINISH.
// Ports    : clk, reset (async, active-high)
//            start_i, op_i[1:0], A_i[31:0], B_i[31:0]  - request
//            busy_o, done_o, result_o[31:0]            - status / result
//            alu_op_o[3:0], alu_a_o, alu_b_o           - drive to shared ALU
//            alu_result_i[31:0]                        - ALU result, same cycle
// Revision : 1.0 - initial release
// ============================================================================
module alu_iter_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] A_i,
  input  logic [31:0] B_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic [3:0]  alu_op_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  input  logic [31:0] alu_result_i
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  localparam logic [1:0] OP_DIVU  = 2'b01;
  localparam logic [1:0] OP_REMU  = 2'b10;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] p_q, p_d;
  logic [31:0] q_q, q_d;
  logic [31:0] result_q, result_d;

  logic        in_is_div;
  logic        is_div;
  logic [31:0] div_shift;
  logic        div_carry;
  logic        div_qbit;

  // Op 11 is reserved and falls through to MUL, so only 01/10 select divide.
  assign in_is_div = (op_i == OP_DIVU) || (op_i == OP_REMU);
  assign is_div    = (op_q == OP_DIVU) || (op_q == OP_REMU);

  // Restoring divide step: the partial remainder is conceptually 33 bits wide;
  // the bit shifted out of p_q forces a subtract since r' then exceeds b_q.
  assign div_shift = {p_q[30:0], q_q[31]};
  assign div_carry = p_q[31];
  assign div_qbit  = div_carry | (div_shift >= b_q);

  // --------------------------------------------------------------------------
  // State register and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      op_q     <= 2'b00;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      p_q      <= 32'd0;
      q_q      <= 32'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      p_q      <= p_d;
      q_q      <= q_d;
      result_q <= result_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (in_is_div && (B_i == 32'd0)) state_d = S_FINISH;
          else                             state_d = S_RUN;
        end
      end
      S_RUN:    if (cnt_q == 5'd31) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath next values
  // --------------------------------------------------------------------------
  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    p_d      = p_q;
    q_d      = q_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d  = op_i;
          a_d   = A_i;
          b_d   = B_i;
          cnt_d = 5'd0;
          p_d   = 32'd0;
          q_d   = in_is_div ? A_i : B_i;
          if (in_is_div && (B_i == 32'd0))
            result_d = (op_i == OP_DIVU) ? 32'hFFFF_FFFF : A_i;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 5'd1;
        if (is_div) begin
          p_d = div_qbit ? alu_result_i : div_shift;
          q_d = {q_q[30:0], div_qbit};
        end else if (q_q[cnt_q]) begin
          p_d = alu_result_i;
        end
        // Result is captured from this step's updated values, not the old ones.
        if (cnt_q == 5'd31)
          result_d = (op_q == OP_DIVU) ? q_d : p_d;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs, decoded from registered state only
  // --------------------------------------------------------------------------
  always_comb begin
    busy_o   = (state_q != S_IDLE);
    done_o   = (state_q == S_FINISH);
    result_o = result_q;
    alu_op_o = ALU_ADD;
    alu_a_o  = 32'd0;
    alu_b_o  = 32'd0;
    if (state_q == S_RUN) begin
      if (is_div) begin
        alu_op_o = ALU_SUB;
        alu_a_o  = div_shift;
        alu_b_o  = b_q;
      end else begin
        alu_op_o = ALU_ADD;
        alu_a_o  = p_q;
        alu_b_o  = a_q << cnt_q;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_iter_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_iter_sequencer
// Purpose  : Directed, table-driven bench for alu_iter_sequencer with a
//            behavioural ADD/SUB ALU and hand-written multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_iter_sequencer;

  logic        clk;
  logic        reset;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] A_i;
  logic [31:0] B_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [3:0]  alu_op_o;
  logic [31:0] alu_a_o;
  logic [31:0] alu_b_o;
  logic [31:0] alu_result_i;

  int tests_run;
  int tests_failed;

  alu_iter_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .op_i         (op_i),
    .A_i          (A_i),
    .B_i          (B_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .result_o     (result_o),
    .alu_op_o     (alu_op_o),
    .alu_a_o      (alu_a_o),
    .alu_b_o      (alu_b_o),
    .alu_result_i (alu_result_i)
  );

  // Shared combinational ALU beside the sequencer.
  assign alu_result_i = (alu_op_o == 4'b0001) ? (alu_a_o - alu_b_o) : (alu_a_o + alu_b_o);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Accept in cycle 0, then count cycles until done; check latency, result,
  // busy throughout, and return to idle the following cycle.
  task automatic run_vec(input int idx, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
    int cyc;
    logic busy_bad;
    @(negedge clk);
    start_i = 1'b1; op_i = op; A_i = a; B_i = b;
    @(negedge clk);
    start_i = 1'b0; A_i = 32'h5A5A_5A5A; B_i = 32'h0000_0003;
    cyc = 1;
    busy_bad = 1'b0;
    while (!done_o && cyc < 60) begin
      if (!busy_o) busy_bad = 1'b1;
      @(negedge clk);
      cyc++;
    end
    if (!busy_o) busy_bad = 1'b1;
    check($sformatf("vec%0d latency", idx), 32'(cyc), 32'(lat));
    check($sformatf("vec%0d result", idx), result_o, exp);
    check($sformatf("vec%0d busy_during", idx), {31'd0, busy_bad}, 32'd0);
    @(negedge clk);
    check($sformatf("vec%0d idle_after", idx), {30'd0, busy_o, done_o}, 32'd0);
  endtask

  initial begin
    int done_cnt;
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1; start_i = 1'b0; op_i = 2'b00; A_i = 32'd0; B_i = 32'd0;

    vecs[0]  = '{2'b00, 32'd7,          32'd6,          32'd42,         33};
    vecs[1]  = '{2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  33};
    vecs[2]  = '{2'b00, 32'h0001_0000,  32'h0001_0000,  32'h0000_0000,  33};
    vecs[3]  = '{2'b01, 32'd100,        32'd7,          32'd14,         33};
    vecs[4]  = '{2'b10, 32'd100,        32'd7,          32'd2,          33};
    vecs[5]  = '{2'b01, 32'hFFFF_FFFF,  32'h8000_0000,  32'h0000_0001,  33};
    vecs[6]  = '{2'b10, 32'hFFFF_FFFF,  32'h8000_0000,  32'h7FFF_FFFF,  33};
    vecs[7]  = '{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[8]  = '{2'b10, 32'd5,          32'd0,          32'd5,          1};
    vecs[9]  = '{2'b11, 32'd3,          32'd5,          32'd15,         33};
    vecs[10] = '{2'b00, 32'h1234_5678,  32'd9,          32'hA3D7_0A38,  33};
    vecs[11] = '{2'b01, 32'd1000000,    32'd1000,       32'd1000,       33};
    vecs[12] = '{2'b10, 32'hDEAD_BEEF,  32'h0000_0010,  32'h0000_000F,  33};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset busy",     {31'd0, busy_o}, 32'd0);
    check("reset done",     {31'd0, done_o}, 32'd0);
    check("reset result",   result_o, 32'd0);
    check("reset alu_op",   {28'd0, alu_op_o}, 32'd0);
    check("reset alu_a",    alu_a_o, 32'd0);
    check("reset alu_b",    alu_b_o, 32'd0);

    for (int i = 0; i < 13; i++)
      run_vec(i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // ---- Starts while busy are ignored; next start after IDLE is accepted ----
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b00; A_i = 32'd3; B_i = 32'd3;
    done_cnt = 0;
    for (int cyc = 1; cyc <= 33; cyc++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (done_o) done_cnt++;
      if (cyc == 1) begin
        check("mul3 c1 alu_op", {28'd0, alu_op_o}, 32'd0);
        check("mul3 c1 alu_a",  alu_a_o, 32'd0);
        check("mul3 c1 alu_b",  alu_b_o, 32'd3);
      end
      if (cyc == 2) begin
        check("mul3 c2 alu_a",  alu_a_o, 32'd3);
        check("mul3 c2 alu_b",  alu_b_o, 32'd6);
      end
      if (cyc == 5 || cyc == 33) begin
        start_i = 1'b1; op_i = 2'b01; A_i = 32'd9; B_i = 32'd3;
      end
    end
    check("ignore done_cyc33", {31'd0, done_o}, 32'd1);
    check("ignore done_count", 32'(done_cnt), 32'd1);
    check("ignore result", result_o, 32'd9);
    @(negedge clk);
    // Cycle 34: idle; start_i still high so this edge accepts DIVU 9/3.
    check("ignore idle_c34", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    start_i = 1'b0;
    check("accept c35 busy", {31'd0, busy_o}, 32'd1);
    check("div c1 alu_op",   {28'd0, alu_op_o}, 32'd1);
    check("div c1 alu_a",    alu_a_o, 32'd0);
    check("div c1 alu_b",    alu_b_o, 32'd3);
    begin
      int n;
      n = 0;
      while (!done_o && n < 60) begin @(negedge clk); n++; end
      check("accept div timeout", {31'd0, done_o}, 32'd1);
      check("accept div result", result_o, 32'd3);
    end
    @(negedge clk);

    // ---- Reset in the middle of a MUL ----
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b00; A_i = 32'd11; B_i = 32'd13;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    #1 reset = 1'b1;
    #1;
    check("midreset busy",   {31'd0, busy_o}, 32'd0);
    check("midreset done",   {31'd0, done_o}, 32'd0);
    check("midreset result", result_o, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (done_o || busy_o) done_cnt++;
    end
    check("midreset no_done", 32'(done_cnt), 32'd0);
    run_vec(99, 2'b00, 32'd2, 32'd2, 32'd4, 33);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
